// File: rtl/dff_bank_ctrl.sv
// dff_bank_ctrl: arbitrates two requesters onto a D flip-flop bank (load, preset, clear).
// Ports: clk; CLR async active-low reset; req[1:0]; cmd0/cmd1 (00 NOP, 01 LOAD, 10 PRESET, 11 CLEAR);
//        data0/data1; ack[1:0] completion pulse; busy; gnt_id; ff_D/ff_en/ff_PRE/ff_CLR bank controls.
// Build option: ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority (requester 0 wins).
`timescale 1ns/1ps
module dff_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [1:0]       req,
    input  logic [1:0]       cmd0,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             gnt_id,
    output logic [WIDTH-1:0] ff_D,
    output logic             ff_en,
    output logic             ff_PRE,
    output logic             ff_CLR
);
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_PULSE = 2'd2, S_ACK = 2'd3;
    localparam logic [1:0] C_NOP = 2'd0, C_LOAD = 2'd1, C_PRE = 2'd2, C_CLR = 2'd3;
    localparam logic [3:0] PC = (PULSE_CYC < 1 || PULSE_CYC > 15) ? 4'd1 : 4'(PULSE_CYC);
    logic [1:0]       state_q, state_d, cmd_q, cmd_d, ack_q;
    logic             gnt_q, gnt_d, busy_q, en_q, pre_q, clr_q, pick;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d, ff_d_q;
`ifdef ROUND_ROBIN_EN
    logic ptr_q;
    assign pick = ptr_q;
    always_ff @(posedge clk or negedge CLR)
        if (!CLR) ptr_q <= 1'b0;
        else if (state_q == S_ACK) ptr_q <= ~gnt_q;
`else
    assign pick = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (|req) begin
                gnt_d   = (req == 2'b11) ? pick : req[1];
                cmd_d   = gnt_d ? cmd1 : cmd0;
                data_d  = gnt_d ? data1 : data0;
                cnt_d   = PC - 4'd1;
                state_d = (cmd_d == C_LOAD) ? S_LOAD : (cmd_d == C_NOP) ? S_ACK : S_PULSE;
            end
            S_LOAD: state_d = S_ACK;
            S_PULSE: begin
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? S_ACK : S_PULSE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so each strobe lines up with the state it belongs to.
    always_ff @(posedge clk or negedge CLR)
        if (!CLR) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            cmd_q   <= C_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 2'b00;
            en_q    <= 1'b0;
            pre_q   <= 1'b0;
            clr_q   <= 1'b0;
            ff_d_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= state_d != S_IDLE;
            ack_q   <= (state_d == S_ACK) ? {gnt_d, ~gnt_d} : 2'b00;
            en_q    <= state_d == S_LOAD;
            pre_q   <= state_d == S_PULSE && cmd_d == C_PRE;
            clr_q   <= state_d == S_PULSE && cmd_d == C_CLR;
            if (state_d == S_LOAD) ff_d_q <= data_d;
        end
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_q;
    assign ff_D   = ff_d_q;
    assign ff_en  = en_q;
    assign ff_PRE = pre_q;
    assign ff_CLR = clr_q;
endmodule

// File: tb/tb_dff_bank_ctrl.sv
// tb_dff_bank_ctrl: directed table, corner sequences and randomized traffic against a timeline model.
`timescale 1ns/1ps
module tb_dff_bank_ctrl;
    localparam int W = 8, P = 3;
    logic clk = 1'b0, CLR = 1'b0;
    logic [1:0] req = 2'b00, cmd0 = 2'b00, cmd1 = 2'b00;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic [1:0] ack;
    logic busy, gnt_id, ff_en, ff_PRE, ff_CLR;
    logic [W-1:0] ff_D;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dff_bank_ctrl #(.WIDTH(W), .PULSE_CYC(P)) dut (
        .clk(clk), .CLR(CLR), .req(req), .cmd0(cmd0), .cmd1(cmd1), .data0(data0), .data1(data1),
        .ack(ack), .busy(busy), .gnt_id(gnt_id), .ff_D(ff_D), .ff_en(ff_en), .ff_PRE(ff_PRE), .ff_CLR(ff_CLR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        CLR = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        CLR = 1'b1;
    endtask

    typedef struct {
        logic [1:0] rq, c0, c1;
        logic [7:0] d0, d1;
        logic       eg;
        logic [1:0] eack;
        int         elat, een, epre, eclr;
        logic [7:0] ed;
    } vec_t;

    typedef struct packed {
        logic       busy, gnt;
        logic [1:0] ack;
        logic       en, pre, clr;
        logic [7:0] d;
    } out_t;

    vec_t tbl[8];
    out_t q[$];
    out_t cur, e;
    logic g, m_ptr;
    logic [1:0] c;
    logic [7:0] d, m_D;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nen, npre, nclr, novl, acks, nbusy;
        logic [1:0] a;
        logic gg;
        tbl[0] = '{2'b01, 2'd1, 2'd0, 8'hA5, 8'h00, 1'b0, 2'b01, 2, 1, 0, 0, 8'hA5};
        tbl[1] = '{2'b10, 2'd0, 2'd2, 8'h00, 8'hFF, 1'b1, 2'b10, 4, 0, 3, 0, 8'hA5};
        tbl[2] = '{2'b11, 2'd3, 2'd1, 8'h77, 8'h3C, 1'b0, 2'b01, 4, 0, 0, 3, 8'hA5};
        tbl[3] = '{2'b01, 2'd0, 2'd1, 8'h99, 8'h66, 1'b0, 2'b01, 1, 0, 0, 0, 8'hA5};
        tbl[4] = '{2'b10, 2'd1, 2'd1, 8'h12, 8'h5A, 1'b1, 2'b10, 2, 1, 0, 0, 8'h5A};
        tbl[5] = '{2'b01, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0, 2'b01, 4, 0, 3, 0, 8'h5A};
`ifdef ROUND_ROBIN_EN
        tbl[6] = '{2'b11, 2'd1, 2'd0, 8'h11, 8'h22, 1'b1, 2'b10, 1, 0, 0, 0, 8'h5A};
`else
        tbl[6] = '{2'b11, 2'd1, 2'd0, 8'h11, 8'h22, 1'b0, 2'b01, 2, 1, 0, 0, 8'h11};
`endif
        tbl[7] = '{2'b10, 2'd0, 2'd3, 8'h00, 8'h00, 1'b1, 2'b10, 4, 0, 0, 3, tbl[6].ed};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_en", 32'(ff_en), 0);
        chk("rst_pre", 32'(ff_PRE), 0);
        chk("rst_clr", 32'(ff_CLR), 0);
        chk("rst_d", 32'(ff_D), 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        CLR = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            req = tbl[i].rq; cmd0 = tbl[i].c0; cmd1 = tbl[i].c1; data0 = tbl[i].d0; data1 = tbl[i].d1;
            lat = 0; nen = 0; npre = 0; nclr = 0; novl = 0; a = 2'b00; gg = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) gg = gnt_id;
                nen += int'(ff_en); npre += int'(ff_PRE); nclr += int'(ff_CLR);
                novl += int'((ff_en & ff_PRE) | (ff_en & ff_CLR) | (ff_PRE & ff_CLR));
                if (ack != 2'b00) begin a = ack; lat = k; break; end
            end
            req = 2'b00;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gg), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_ack", i), 32'(a), 32'(tbl[i].eack));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
            chk($sformatf("tbl%0d_en", i), 32'(nen), 32'(tbl[i].een));
            chk($sformatf("tbl%0d_pre", i), 32'(npre), 32'(tbl[i].epre));
            chk($sformatf("tbl%0d_clr", i), 32'(nclr), 32'(tbl[i].eclr));
            chk($sformatf("tbl%0d_ovl", i), 32'(novl), 0);
            chk($sformatf("tbl%0d_d", i), 32'(ff_D), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_busy_after", i), 32'(busy), 0);
        end

        do_reset();
        @(negedge clk);
        req = 2'b01; cmd0 = 2'd1; data0 = 8'hC3;
        @(negedge clk);
        req = 2'b00; data0 = 8'h00;
        chk("drop_en", 32'(ff_en), 1);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(ack[0]);
        end
        chk("drop_acks", 32'(acks), 1);
        chk("drop_d", 32'(ff_D), 32'hC3);

        do_reset();
        @(negedge clk);
        req = 2'b11; cmd0 = 2'd3; cmd1 = 2'd3;
        for (int n = 0; n < 4; n++) begin
            a = 2'b00;
            for (int k = 0; k < 20 && a == 2'b00; k++) begin
                @(negedge clk);
                a = ack;
            end
`ifdef ROUND_ROBIN_EN
            chk($sformatf("both_ack%0d", n), 32'(a), (n % 2 == 0) ? 32'h1 : 32'h2);
`else
            chk($sformatf("both_ack%0d", n), 32'(a), 32'h1);
`endif
        end
        req = 2'b00;

        do_reset();
        @(negedge clk);
        req = 2'b01; cmd0 = 2'd3;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        chk("abort_clr_before", 32'(ff_CLR), 1);
        CLR = 1'b0;
        #1;
        chk("abort_clr", 32'(ff_CLR), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ack), 0);
        @(negedge clk);
        CLR = 1'b1;
        acks = 0; nbusy = 0;
        repeat (5) begin
            @(negedge clk);
            acks += int'(ack != 2'b00);
            nbusy += int'(busy);
        end
        chk("abort_no_ack", 32'(acks), 0);
        chk("abort_idle", 32'(nbusy), 0);

        do_reset();
        m_D = 8'h00; m_ptr = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            if (q.size() == 0 && req != 2'b00) begin
`ifdef ROUND_ROBIN_EN
                g = (req == 2'b11) ? m_ptr : req[1];
`else
                g = (req == 2'b11) ? 1'b0 : req[1];
`endif
                c = g ? cmd1 : cmd0;
                d = g ? data1 : data0;
                e = '{busy: 1'b1, gnt: g, ack: 2'b00, en: 1'b0, pre: 1'b0, clr: 1'b0, d: m_D};
                if (c == 2'd1) begin
                    e.en = 1'b1; e.d = d; m_D = d;
                    q.push_back(e);
                    e.en = 1'b0;
                end else if (c != 2'd0) begin
                    e.pre = (c == 2'd2); e.clr = (c == 2'd3);
                    repeat (P) q.push_back(e);
                    e.pre = 1'b0; e.clr = 1'b0;
                end
                e.ack = g ? 2'b10 : 2'b01;
                q.push_back(e);
                q.push_back('{busy: 1'b0, gnt: 1'b0, ack: 2'b00, en: 1'b0, pre: 1'b0, clr: 1'b0, d: m_D});
                m_ptr = ~g;
            end
            if (q.size() != 0) cur = q.pop_front();
            else cur = '{busy: 1'b0, gnt: 1'b0, ack: 2'b00, en: 1'b0, pre: 1'b0, clr: 1'b0, d: m_D};
            #1;
            chk($sformatf("rand_cyc%0d", cyc),
                32'({busy, busy & gnt_id, ack, ff_en, ff_PRE, ff_CLR, ff_D}),
                32'({cur.busy, cur.busy & cur.gnt, cur.ack, cur.en, cur.pre, cur.clr, cur.d}));
            for (int i = 0; i < 2; i++) begin
                if (cur.ack[i]) req[i] = 1'b0;
                else if (req[i] && cur.busy && cur.gnt == 1'(i) && $urandom_range(15) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
                if ($urandom_range(3) == 0) begin
                    if (i == 0) begin cmd0 = 2'($urandom); data0 = 8'($urandom); end
                    else begin cmd1 = 2'($urandom); data1 = 8'($urandom); end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dff_bank_ctrl.md
DFF_BANK_CTRL -- requirements
Module: dff_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the controlled D flip-flop bank and of each data port.
REQ-002 Parameter PULSE_CYC, default 2, legal range 1..15: number of cycles a preset or clear pulse is held.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 CLR  input  1  reset; asynchronous, active-low.
REQ-005 req  input  2  per-requester request; req[i] is held high until ack[i].
REQ-006 cmd0, cmd1  input  2 each  requester command: 00 NOP, 01 LOAD, 10 PRESET, 11 CLEAR.
REQ-007 data0, data1  input  WIDTH each  requester load data.
REQ-008 ack  output  2  one-cycle completion pulse per requester.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 gnt_id  output  1  index of the requester currently granted; valid while busy.
REQ-011 ff_D  output  WIDTH  data driven to the bank D inputs.
REQ-012 ff_en  output  1  one-cycle load strobe to the bank.
REQ-013 ff_PRE  output  1  active-high preset pulse to the bank.
REQ-014 ff_CLR  output  1  active-high clear pulse to the bank.

Function
REQ-015 FSM states: IDLE, LOAD, PULSE, ACK; all outputs are registered.
REQ-016 IDLE: when any req is high at edge N, the controller grants one requester and latches its cmd and data into internal registers.
REQ-017 Latched cmd LOAD: FSM goes to LOAD; in cycle N+1, ff_en=1 and ff_D=the latched data.
REQ-018 Latched cmd PRESET/CLEAR: FSM goes to PULSE; ff_PRE or ff_CLR is high for exactly PULSE_CYC cycles, N+1..N+PULSE_CYC, driven by a 4-bit down-counter.
REQ-019 Latched cmd NOP: FSM goes directly to ACK; no bank strobe is issued.
REQ-020 ACK lasts one cycle: ack[gnt_id]=1, then FSM returns to IDLE; LOAD acks at N+2, PRESET/CLEAR ack at N+PULSE_CYC+1, NOP acks at N+1.
REQ-021 A new grant occurs no earlier than the IDLE cycle following ACK; back-to-back operations therefore have at least one idle cycle between them.
REQ-022 ff_PRE and ff_CLR are never high in the same cycle; ff_en is never high together with either.
REQ-023 ff_D holds its last loaded value outside LOAD; it is reset to 0.
REQ-024 Changes to req, cmd or data after the grant are ignored until ACK; if req drops mid-operation, the operation still completes and ack is still pulsed.
REQ-025 Arbitration when both req are high in IDLE follows REQ-030/REQ-031; a single request is always granted regardless of priority state.
REQ-026 A PULSE_CYC value outside 1..15 is clamped to 1.

Reset
REQ-027 CLR low asynchronously forces IDLE and clears ack, busy, gnt_id, ff_en, ff_PRE, ff_CLR, ff_D, the pulse counter and the priority pointer.
REQ-028 Reset asserted mid-operation aborts the operation immediately, with no ack; any active ff_PRE or ff_CLR pulse is truncated in the same instant.
REQ-029 After CLR deasserts, the first rising edge may grant a request.

Configuration
REQ-030 Macro ROUND_ROBIN_EN defined: the priority pointer starts at requester 0 after reset; after each ACK it points to the requester not just served; simultaneous requests go to the pointer.
REQ-031 ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins simultaneous requests, and no pointer register exists.

Verification
REQ-032 Reset, then req=01, cmd0=LOAD, data0=8'hA5 -> ff_en=1 with ff_D=8'hA5 at N+1, ack=01 at N+2, busy low at N+3.
REQ-033 req=10, cmd1=PRESET, PULSE_CYC=3 -> ff_PRE high exactly 3 cycles, ff_CLR and ff_en stay 0 throughout, ack=10 one cycle after the pulse ends.
REQ-034 req=11 held continuously, both cmds CLEAR -> with ROUND_ROBIN_EN, grants alternate 0,1,0,1; without it, requester 0 is always granted.
REQ-035 CLR pulsed low during cycle 2 of a 3-cycle CLEAR pulse -> ff_CLR and busy drop immediately, no ack is issued, and the state is IDLE after release.
REQ-036 req0 drops one cycle after the grant of a LOAD -> the load still completes and ack[0] pulses once; cmd0=NOP -> ack at N+1 with no strobe.
